spi_reg_master: RTL and testbench
=================================

SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 3..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: clk cycles SS_N is held high between frames; legal range 3..255.
REQ-003 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  in  1  command request.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when valid && ready.
REQ-007 SHALL have port cmd  in  4  register command code.
REQ-008 SHALL have port data  in  24  payload, right-aligned, so that only data[LEN-1:0] is sent.
REQ-009 SHALL have port busy  out  1  high from acceptance until done.
REQ-010 SHALL have port done  out  1  one-cycle pulse when a frame and its gap complete.
REQ-011 SHALL have ports o_sclk, o_ss_n, o_mosi  out  1 each  SPI mode-0 master outputs.

Function
REQ-012 SHALL use these LEN values per cmd: 0/1/2/4 -> 6; 3 -> 12; 5 -> 1; 6 -> 16; 7..10 -> 24; 11..15 -> 1 (framing only, with data[0] sent).
REQ-013 SHALL send a frame of N = 4 + LEN bits: cmd[3] down to cmd[0], then data[LEN-1] down to data[0], MSB first.
REQ-014 SHALL capture cmd and data into internal registers on acceptance; later input changes SHALL NOT affect the frame in flight.
REQ-015 SHALL use FSM states IDLE -> SETUP -> HIGH <-> LOW -> TAIL -> GAP -> IDLE.
REQ-016 SHALL, on acceptance at cycle T, enter SETUP at T+1 with o_ss_n=0, o_sclk=0 and o_mosi=bit 0, and remain in SETUP for CLK_DIV cycles.
REQ-017 SHALL hold each HIGH phase for CLK_DIV cycles with o_sclk=1; o_mosi SHALL be stable throughout.
REQ-018 SHALL hold each LOW phase for CLK_DIV cycles with o_sclk=0; o_mosi SHALL update to the next bit only on the first LOW cycle.
REQ-019 SHALL, after the HIGH phase of bit N-1, enter TAIL instead of LOW: o_sclk=0, o_ss_n=0, o_mosi held, for CLK_DIV cycles.
REQ-020 SHALL keep o_ss_n low for exactly CLK_DIV*(2N+1) cycles per frame, giving exactly N o_sclk rising edges.
REQ-021 SHALL, in GAP, drive o_ss_n=1, o_sclk=0 and o_mosi=0 for GAP_CYCLES cycles.
REQ-022 SHALL pulse done in the cycle after GAP ends, which is also the first IDLE cycle.
REQ-023 SHALL drive cmd_ready=1 only in IDLE, subject to REQ-029.
REQ-024 SHALL drive busy = (state != IDLE).
REQ-025 SHALL size the bit counter at 5 bits (max N = 28) and the phase counter at 8 bits.
REQ-026 SHALL NOT let the phase counter wrap; it reloads at each phase change.

Reset
REQ-027 SHALL, on reset, take effect on the next edge from any state: state=IDLE, o_sclk=0, o_ss_n=1, o_mosi=0, busy=0, done=0, cmd_ready=1, pending slot empty.
REQ-028 SHALL treat a reset in mid-frame as an abort: o_ss_n rises without a TAIL phase, no done pulse is issued, and the receiver discards the partial frame.

Configuration
REQ-029 SHALL, with SPI_REG_MASTER_PENDING_EN defined, provide a one-entry pending slot:
- cmd_ready = IDLE || slot empty.
- A command accepted while busy is stored in the slot.
- On GAP end, a filled slot launches directly into SETUP in the same cycle done pulses, and the slot empties.
- Simultaneous done and acceptance in IDLE with an empty slot starts the new frame directly.
REQ-030 SHALL, without SPI_REG_MASTER_PENDING_EN, have no slot; cmd_ready = (state == IDLE).

Structure
REQ-031 SHALL take CMD_* codes, LEN_* values and the cmd->LEN lookup function from the shared include used by the SPI register receiver; that include SHALL be the single source of truth for both ends.
REQ-032 SHALL be a single module with no sub-modules; the divider, bit counter and FSM are inline.

Verification
REQ-033 SHALL verify: cmd=0, data=6'b110011, CLK_DIV=4 -> o_mosi sampled at 10 rises = 0000110011; o_ss_n low 84 cycles; done 4 cycles after o_ss_n rises (GAP_CYCLES=4).
REQ-034 SHALL verify: cmd=7, data=24'hA5C3F0 -> 28 rises carrying 0111 followed by A5C3F0 MSB first; data changed mid-frame has no effect.
REQ-035 SHALL verify: cmd=15, data=24'h000001 -> 5 rises carrying 1111 then 1; o_ss_n low 44 cycles.
REQ-036 SHALL verify: reset asserted at the 3rd rise of a cmd=3 frame -> next cycle o_ss_n=1, o_sclk=0, no done pulse; the receiver's buffered registers are unchanged.
REQ-037 SHALL verify, in loopback into the receiver: cmd=3, data=12'hABC, then load_new -> otherx=6'h2A, othery=6'h3C.
REQ-038 SHALL verify back-to-back cmd_valid for two commands:
- With SPI_REG_MASTER_PENDING_EN: the second is accepted while busy and its o_ss_n falls on the done cycle of the first.
- Without it: cmd_ready stays low until done.

Source files
------------

// File: rtl/spi_reg_master_pkg.sv
// Shared SPI register-link definitions: command codes, payload lengths, the
// cmd -> payload-length lookup and the frame packer. Both the master and the
// receiver use this package, so the frame format is defined in one place.
//
// Contents:
//   CMD_*       4-bit register command codes
//   LEN_*       payload lengths in bits
//   cmd_len     payload length for a command code
//   frame_bits  total frame length (command nibble + payload)
//   pack_frame  left-aligned frame image, first bit to send in the MSB
//   state_e     master FSM state encoding
package spi_reg_master_pkg;

  localparam int unsigned CMD_W     = 4;
  localparam int unsigned DATA_W    = 24;
  localparam int unsigned FRAME_MAX = CMD_W + DATA_W;

  localparam logic [3:0] CMD_SELFX   = 4'd0;
  localparam logic [3:0] CMD_SELFY   = 4'd1;
  localparam logic [3:0] CMD_SELFZ   = 4'd2;
  localparam logic [3:0] CMD_OTHERXY = 4'd3;
  localparam logic [3:0] CMD_SELFW   = 4'd4;
  localparam logic [3:0] CMD_LOAD    = 4'd5;
  localparam logic [3:0] CMD_COLOR   = 4'd6;
  localparam logic [3:0] CMD_WIDE0   = 4'd7;
  localparam logic [3:0] CMD_WIDE1   = 4'd8;
  localparam logic [3:0] CMD_WIDE2   = 4'd9;
  localparam logic [3:0] CMD_WIDE3   = 4'd10;

  localparam logic [4:0] LEN_1  = 5'd1;
  localparam logic [4:0] LEN_6  = 5'd6;
  localparam logic [4:0] LEN_12 = 5'd12;
  localparam logic [4:0] LEN_16 = 5'd16;
  localparam logic [4:0] LEN_24 = 5'd24;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StTail,
    StGap
  } state_e;

  // Codes 11..15 are framing-only: a single payload bit (data[0]) follows.
  function automatic logic [4:0] cmd_len(input logic [3:0] c);
    logic [4:0] len;
    case (c)
      CMD_SELFX, CMD_SELFY, CMD_SELFZ, CMD_SELFW:     len = LEN_6;
      CMD_OTHERXY:                                    len = LEN_12;
      CMD_LOAD:                                       len = LEN_1;
      CMD_COLOR:                                      len = LEN_16;
      CMD_WIDE0, CMD_WIDE1, CMD_WIDE2, CMD_WIDE3:     len = LEN_24;
      default:                                        len = LEN_1;
    endcase
    return len;
  endfunction

  function automatic logic [4:0] frame_bits(input logic [3:0] c);
    return 5'(CMD_W) + cmd_len(c);
  endfunction

  // Payload is right-aligned on input; only data[len-1:0] is kept and moved up
  // to sit directly below the command nibble.
  function automatic logic [FRAME_MAX-1:0] pack_frame(input logic [3:0]  c,
                                                      input logic [23:0] d);
    logic [4:0]  len;
    logic [23:0] mask;
    logic [23:0] body;
    len  = cmd_len(c);
    mask = (24'd1 << len) - 24'd1;
    body = (d & mask) << (5'd24 - len);
    return {c, body};
  endfunction

endpackage

// File: rtl/spi_reg_master.sv
// SPI mode-0 register-write master. Accepts a 4-bit command plus right-aligned
// payload, and shifts out cmd[3:0] then data[LEN-1:0] MSB first, with a trailing
// half-period before SS_N rises and an enforced inter-frame gap.
//
// Parameters:
//   CLK_DIV     clk cycles per SCLK half-period (3..255)
//   GAP_CYCLES  clk cycles SS_N stays high between frames (3..255)
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd/data captured on acceptance
//   cmd, data             command code and right-aligned payload
//   busy                  high whenever the FSM is not idle
//   done                  one-cycle pulse on the first cycle after the gap
//   o_sclk/o_ss_n/o_mosi  SPI outputs
// Build option:
//   SPI_REG_MASTER_PENDING_EN  adds a one-entry command slot so a new command can
//                              be accepted while a frame is in flight.
module spi_reg_master
  import spi_reg_master_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd,
  input  logic [23:0] data,
  output logic        busy,
  output logic        done,
  output logic        o_sclk,
  output logic        o_ss_n,
  output logic        o_mosi
);

  localparam logic [7:0] DivReload = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapReload = 8'(GAP_CYCLES - 1);

  state_e                state_q, state_d;
  logic [7:0]            phase_q, phase_d;
  // Bits still to send after the one currently on MOSI.
  logic [4:0]            bits_q, bits_d;
  logic [FRAME_MAX-1:0]  shift_q, shift_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  phase_end;
  logic                  launch;
  logic [3:0]            launch_cmd;
  logic [23:0]           launch_data;

`ifdef SPI_REG_MASTER_PENDING_EN
  logic                  slot_full_q, slot_full_d;
  logic [3:0]            slot_cmd_q, slot_cmd_d;
  logic [23:0]           slot_data_q, slot_data_d;

  assign cmd_ready = (state_q == StIdle) || !slot_full_q;
`else
  assign cmd_ready = (state_q == StIdle);
`endif

  assign accept    = cmd_valid && cmd_ready;
  assign phase_end = (phase_q == 8'd0);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bits_d      = bits_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    launch      = 1'b0;
    launch_cmd  = cmd;
    launch_data = data;
`ifdef SPI_REG_MASTER_PENDING_EN
    slot_full_d = slot_full_q;
    slot_cmd_d  = slot_cmd_q;
    slot_data_d = slot_data_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) launch = 1'b1;
      end
      StSetup: begin
        if (phase_end) begin
          state_d = StHigh;
          phase_d = DivReload;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      StHigh: begin
        if (phase_end) begin
          phase_d = DivReload;
          if (bits_q == 5'd0) begin
            // Last bit: hold MOSI through a trailing low half-period.
            state_d = StTail;
          end else begin
            state_d = StLow;
            bits_d  = bits_q - 5'd1;
            shift_d = shift_q << 1;
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      StLow: begin
        if (phase_end) begin
          state_d = StHigh;
          phase_d = DivReload;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      StTail: begin
        if (phase_end) begin
          state_d = StGap;
          phase_d = GapReload;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      StGap: begin
        if (phase_end) begin
          done_d  = 1'b1;
          state_d = StIdle;
`ifdef SPI_REG_MASTER_PENDING_EN
          if (slot_full_q) begin
            launch      = 1'b1;
            launch_cmd  = slot_cmd_q;
            launch_data = slot_data_q;
            slot_full_d = 1'b0;
          end else if (accept) begin
            // Empty slot and a command arriving right now: start it directly.
            launch = 1'b1;
          end
`endif
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      state_d = StSetup;
      phase_d = DivReload;
      shift_d = pack_frame(launch_cmd, launch_data);
      bits_d  = frame_bits(launch_cmd) - 5'd1;
    end

`ifdef SPI_REG_MASTER_PENDING_EN
    // An accepted command that did not launch must have arrived while busy.
    if (accept && !launch) begin
      slot_full_d = 1'b1;
      slot_cmd_d  = cmd;
      slot_data_d = data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      phase_q <= 8'd0;
      bits_q  <= 5'd0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_REG_MASTER_PENDING_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_full_q <= 1'b0;
      slot_cmd_q  <= 4'd0;
      slot_data_q <= 24'd0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_cmd_q  <= slot_cmd_d;
      slot_data_q <= slot_data_d;
    end
  end
`endif

  logic in_frame;
  assign in_frame = (state_q == StSetup) || (state_q == StHigh) ||
                    (state_q == StLow)   || (state_q == StTail);

  assign o_ss_n = !in_frame;
  assign o_sclk = (state_q == StHigh);
  assign o_mosi = in_frame ? shift_q[FRAME_MAX-1] : 1'b0;
  assign busy   = (state_q != StIdle);
  assign done   = done_q;

endmodule

// File: tb/tb_spi_reg_master.sv
module tb_spi_reg_master;
  import spi_reg_master_pkg::*;

  localparam int DIV = 4;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd = 4'd0;
  logic [23:0] data = 24'd0;
  logic        busy, done, o_sclk, o_ss_n, o_mosi;

  spi_reg_master #(.CLK_DIV(DIV), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .data(data), .busy(busy), .done(done),
    .o_sclk(o_sclk), .o_ss_n(o_ss_n), .o_mosi(o_mosi)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [27:0] bits;
    int          n;
    bit          abort;
  } exp_t;

  exp_t exp_q[$];

  // Receiver model: buffered other-x/y registers and their loaded copies.
  logic [5:0] buf_x = 6'd0, buf_y = 6'd0, otherx = 6'd0, othery = 6'd0;

  // Monitor state
  logic        prev_ss_n = 1'b1, prev_sclk = 1'b0, rise_mosi = 1'b0;
  logic [27:0] bits = '0;
  int          nrise = 0, low_cnt = 0, gap_cnt = 0;
  bit          glitch = 0, done_pending = 0;

  task automatic frame_end();
    exp_t e;
    logic [3:0] rx_cmd;
    if (nrise >= 4) begin
      rx_cmd = 4'(bits >> (nrise - 4));
      if (rx_cmd == CMD_OTHERXY && nrise == 4 + int'(cmd_len(rx_cmd))) begin
        buf_x = bits[11:6];
        buf_y = bits[5:0];
      end
    end
    if (exp_q.size() == 0) begin
      chk("unexpected_frame", 32'(nrise), 32'hFFFF_FFFF);
      return;
    end
    e = exp_q.pop_front();
    if (e.abort) begin
      chk("abort_rises", 32'(nrise), 32'd3);
    end else begin
      chk("frame_rises", 32'(nrise), 32'(e.n));
      chk("frame_bits", 32'(bits), 32'(e.bits));
      chk("ss_low_cycles", 32'(low_cnt), 32'(DIV * (2 * e.n + 1)));
      chk("mosi_stable_high", 32'(glitch), 32'd0);
      done_pending = 1;
      gap_cnt = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done_pending) gap_cnt++;
      if (done) begin
        if (done_pending) chk("done_after_ss_rise", 32'(gap_cnt), 32'(GAP));
        else chk("unexpected_done", 32'(done), 32'd0);
        done_pending = 0;
      end
      if (!o_ss_n) begin
        if (prev_ss_n) begin
          low_cnt = 0; nrise = 0; bits = '0; glitch = 0;
        end
        low_cnt++;
        if (o_sclk && !prev_sclk) begin
          bits = {bits[26:0], o_mosi};
          nrise++;
          rise_mosi = o_mosi;
        end else if (o_sclk && (o_mosi !== rise_mosi)) begin
          glitch = 1;
        end
      end else if (!prev_ss_n) begin
        frame_end();
      end
      prev_ss_n = o_ss_n;
      prev_sclk = o_sclk;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [23:0] d, input logic [27:0] eb,
                       input int n, input bit abort, output bit acc_busy, output bit acc_done);
    exp_t e;
    bit   ok = 0;
    e.bits = eb; e.n = n; e.abort = abort;
    exp_q.push_back(e);
    acc_busy = 0; acc_done = 0;
    cmd_valid = 1'b1; cmd = c; data = d;
    for (int i = 0; i < 3000; i++) begin
      if (cmd_ready) begin
        acc_busy = busy;
        acc_done = done;
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic load_new();
    otherx = buf_x;
    othery = buf_y;
  endtask

  bit ab, ad;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ss_n", 32'(o_ss_n), 32'd1);
    chk("rst_sclk", 32'(o_sclk), 32'd0);
    chk("rst_mosi", 32'(o_mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    issue(4'd0, 24'b110011, 28'b0000110011, 10, 0, ab, ad);
    wait_idle();

    issue(4'd7, 24'hA5C3F0, {4'h7, 24'hA5C3F0}, 28, 0, ab, ad);
    // Inputs change mid-frame; the frame in flight must not notice.
    repeat (20) @(posedge clk);
    #1;
    cmd = 4'h2; data = 24'h5A3C0F;
    wait_idle();

    issue(4'd15, 24'h000001, 28'b11111, 5, 0, ab, ad);
    wait_idle();
    issue(4'd6, 24'h12BEEF, {8'h0, 4'h6, 16'hBEEF}, 20, 0, ab, ad);
    wait_idle();
    issue(4'd4, 24'hFFFFC5, {18'h0, 4'h4, 6'h05}, 10, 0, ab, ad);
    wait_idle();

    issue(4'd3, 24'h000ABC, {12'h0, 16'h3ABC}, 16, 0, ab, ad);
    wait_idle();
    load_new();
    chk("otherx", 32'(otherx), 32'h2A);
    chk("othery", 32'(othery), 32'h3C);

    // Abort a cmd=3 frame at its third SCLK rise.
    issue(4'd3, 24'h000123, 28'h0, 16, 1, ab, ad);
    begin
      bit seen = 0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk); #1;
        if (nrise >= 3) begin seen = 1; break; end
      end
      if (!seen) chk("abort_wait_timeout", 32'd0, 32'd1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_ss_n", 32'(o_ss_n), 32'd1);
    chk("abort_sclk", 32'(o_sclk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    load_new();
    chk("abort_otherx", 32'(otherx), 32'h2A);
    chk("abort_othery", 32'(othery), 32'h3C);

    // Back-to-back commands.
    issue(4'd5, 24'h000000, 28'b01010, 5, 0, ab, ad);
    issue(4'd1, 24'h00002D, {18'h0, 4'h1, 6'h2D}, 10, 0, ab, ad);
`ifdef SPI_REG_MASTER_PENDING_EN
    chk("b2b_accept_busy", 32'(ab), 32'd1);
    begin
      bit seen = 0;
      for (int i = 0; i < 500; i++) begin
        if (done) begin seen = 1; break; end
        @(posedge clk); #1;
      end
      chk("b2b_done_seen", 32'(seen), 32'd1);
      chk("b2b_ss_fall_on_done", 32'(o_ss_n), 32'd0);
    end
`else
    chk("b2b_ready_at_done", 32'(ad), 32'd1);
    chk("b2b_accept_idle", 32'(ab), 32'd0);
`endif
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("no_done_owed", 32'(done_pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
